// File: rtl/stream_feed_checker.sv
// stream_feed_checker
//   Feeds a valid/ready byte stream into a device under test (data/en/
//   stream_end, throttled by prog_full) and checks the device's output
//   stream, in order, against a FIFO of the words that were fed.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   clk_en                global enable; all state holds while low
//   src_*                 source stream (valid/ready, last marks final word)
//   dut_data/en/stream_end, dut_prog_full   feed side towards the device
//   chk_data/en           device output stream
//   in_cnt, out_cnt, down_time, err_cnt, first_err_idx   saturating counters
//   err_flag, underrun, timeout, done                   sticky status
//
// state | meaning
// FEED  | accepting source words, checking returned words
// DRAIN | last word fed, waiting for the device to return the remainder
// DONE  | run finished (all words returned or drain timed out)
// HALT  | first error seen with STOP_ON_ERR=1, everything frozen
module stream_feed_checker #(
  parameter int DATA_W        = 8,
  parameter int DEPTH         = 64,
  parameter int CNT_W         = 32,
  parameter int STOP_ON_ERR   = 0,
  parameter int DRAIN_TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_en,
  input  logic [DATA_W-1:0] src_data,
  input  logic              src_valid,
  input  logic              src_last,
  output logic              src_ready,
  output logic [DATA_W-1:0] dut_data,
  output logic              dut_en,
  output logic              dut_stream_end,
  input  logic              dut_prog_full,
  input  logic [DATA_W-1:0] chk_data,
  input  logic              chk_en,
  output logic [CNT_W-1:0]  in_cnt,
  output logic [CNT_W-1:0]  out_cnt,
  output logic [CNT_W-1:0]  down_time,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]  first_err_idx,
  output logic              err_flag,
  output logic              underrun,
  output logic              timeout,
  output logic              done
);

  localparam int AW = $clog2(DEPTH);
  localparam int IW = $clog2(DRAIN_TIMEOUT + 1);

  typedef enum logic [1:0] {S_FEED, S_DRAIN, S_DONE, S_HALT} state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr;
  logic              fifo_empty, fifo_full;
  logic [IW-1:0]     idle_cnt;

  logic xfer, chk_act, pop, mism, under_evt, err_evt, drain_empty, drain_to;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign done       = (state == S_DONE);

  always_comb begin
    src_ready   = rst_n & clk_en & (state == S_FEED) & ~dut_prog_full & ~fifo_full;
    xfer        = src_valid & src_ready;
    chk_act     = clk_en & chk_en & ((state == S_FEED) | (state == S_DRAIN));
    // The check always looks at the pre-push FIFO contents.
    pop         = chk_act & ~fifo_empty;
    mism        = pop & (chk_data != mem[rd_ptr[AW-1:0]]);
    under_evt   = chk_act & fifo_empty;
    err_evt     = mism | under_evt;
    drain_empty = (state == S_DRAIN) & (wr_ptr == (rd_ptr + pop));
    drain_to    = (state == S_DRAIN) & ~chk_en & (idle_cnt == IW'(DRAIN_TIMEOUT - 1));

    state_nxt = state;
    case (state)
      S_FEED:  if (xfer && src_last) state_nxt = S_DRAIN;
      S_DRAIN: if (drain_empty || drain_to) state_nxt = S_DONE;
      default: state_nxt = state;
    endcase
    if ((STOP_ON_ERR != 0) && err_evt && !err_flag) state_nxt = S_HALT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      state <= S_FEED;
    else if (clk_en) state <= state_nxt;
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (xfer) mem[wr_ptr[AW-1:0]] <= src_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      dut_data       <= '0;
      dut_en         <= 1'b0;
      dut_stream_end <= 1'b0;
      in_cnt         <= '0;
      out_cnt        <= '0;
      down_time      <= '0;
      err_cnt        <= '0;
      first_err_idx  <= '0;
      err_flag       <= 1'b0;
      underrun       <= 1'b0;
      timeout        <= 1'b0;
      idle_cnt       <= '0;
    end else if (clk_en) begin
      dut_en <= xfer;
      if (xfer) begin
        dut_data <= src_data;
        wr_ptr   <= wr_ptr + 1'b1;
        in_cnt   <= sat_inc(in_cnt);
        if (src_last) dut_stream_end <= 1'b1;
      end
      if ((state == S_FEED) && dut_prog_full) down_time <= sat_inc(down_time);
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        out_cnt <= sat_inc(out_cnt);
      end
      if (err_evt) begin
        err_cnt  <= sat_inc(err_cnt);
        err_flag <= 1'b1;
        if (!err_flag) first_err_idx <= out_cnt;
      end
      if (under_evt) underrun <= 1'b1;
      if (state == S_DRAIN) idle_cnt <= chk_en ? '0 : idle_cnt + 1'b1;
      if (drain_to) timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_stream_feed_checker.sv
// Directed bench for stream_feed_checker. A queue-based model follows the
// behavioural rules and is compared against the main instance every cycle;
// a second instance with STOP_ON_ERR=1 shares the stimulus and is pinned with
// literal expectations in the corruption test.
module tb_stream_feed_checker;
  localparam int DW = 8, DEPTH = 64, CW = 32, TO = 1024;

  logic clk = 1'b0, rst_n = 1'b0, clk_en = 1'b0;
  logic [DW-1:0] src_data = '0;
  logic src_valid = 1'b0, src_last = 1'b0, dut_prog_full = 1'b0;
  logic [DW-1:0] chk_data = '0;
  logic chk_en = 1'b0;

  logic src_ready, dut_en, dut_stream_end, err_flag, underrun, timeout, done;
  logic [DW-1:0] dut_data;
  logic [CW-1:0] in_cnt, out_cnt, down_time, err_cnt, first_err_idx;

  logic h_src_ready, h_dut_en, h_dut_stream_end, h_err_flag, h_underrun, h_timeout, h_done;
  logic [DW-1:0] h_dut_data;
  logic [CW-1:0] h_in_cnt, h_out_cnt, h_down_time, h_err_cnt, h_first_err_idx;

  always #5 clk = ~clk;

  stream_feed_checker #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CW), .STOP_ON_ERR(0), .DRAIN_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .src_data(src_data), .src_valid(src_valid),
    .src_last(src_last), .src_ready(src_ready), .dut_data(dut_data), .dut_en(dut_en),
    .dut_stream_end(dut_stream_end), .dut_prog_full(dut_prog_full), .chk_data(chk_data),
    .chk_en(chk_en), .in_cnt(in_cnt), .out_cnt(out_cnt), .down_time(down_time), .err_cnt(err_cnt),
    .first_err_idx(first_err_idx), .err_flag(err_flag), .underrun(underrun), .timeout(timeout),
    .done(done));

  stream_feed_checker #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CW), .STOP_ON_ERR(1), .DRAIN_TIMEOUT(TO)) dut_h (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .src_data(src_data), .src_valid(src_valid),
    .src_last(src_last), .src_ready(h_src_ready), .dut_data(h_dut_data), .dut_en(h_dut_en),
    .dut_stream_end(h_dut_stream_end), .dut_prog_full(dut_prog_full), .chk_data(chk_data),
    .chk_en(chk_en), .in_cnt(h_in_cnt), .out_cnt(h_out_cnt), .down_time(h_down_time),
    .err_cnt(h_err_cnt), .first_err_idx(h_first_err_idx), .err_flag(h_err_flag),
    .underrun(h_underrun), .timeout(h_timeout), .done(h_done));

  int n_checks = 0, n_errs = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errs++;
      if (n_errs <= 40) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_st: 0 feeding, 1 draining, 2 finished
  logic [DW-1:0] mq[$];
  int m_st, m_idle;
  longint m_in, m_out, m_down, m_err, m_first, ob;
  bit m_en, m_end, m_eflag, m_under, m_tout, rdy, xf, err_e;
  logic [DW-1:0] m_data, head;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_st = 0; m_idle = 0; m_in = 0; m_out = 0; m_down = 0; m_err = 0; m_first = 0;
      m_en = 0; m_end = 0; m_eflag = 0; m_under = 0; m_tout = 0; m_data = '0;
    end else if (clk_en) begin
      rdy = (m_st == 0) && !dut_prog_full && (mq.size() < DEPTH);
      xf = src_valid && rdy;
      m_en = xf;
      if (xf) m_data = src_data;
      if (m_st == 0 && dut_prog_full) m_down++;
      if (chk_en && m_st < 2) begin
        ob = m_out;
        if (mq.size() > 0) begin
          head = mq.pop_front();
          err_e = (head != chk_data);
          m_out++;
        end else begin
          m_under = 1;
          err_e = 1;
        end
        if (err_e) begin
          m_err++;
          if (!m_eflag) m_first = ob;
          m_eflag = 1;
        end
      end
      if (xf) begin
        mq.push_back(src_data);
        m_in++;
      end
      if (m_st == 1) begin
        if (chk_en) m_idle = 0; else m_idle++;
        if (mq.size() == 0) m_st = 2;
        else if (m_idle == TO) begin
          m_tout = 1;
          m_st = 2;
        end
      end else if (m_st == 0 && xf && src_last) begin
        m_end = 1;
        m_st = 1;
      end
    end
  end

  bit m_rdy;
  always @(negedge clk) begin
    m_rdy = rst_n && clk_en && (m_st == 0) && !dut_prog_full && (mq.size() < DEPTH);
    check("src_ready", src_ready, m_rdy);
    check("dut_en", dut_en, m_en);
    check("dut_data", dut_data, m_data);
    check("dut_stream_end", dut_stream_end, m_end);
    check("in_cnt", in_cnt, m_in);
    check("out_cnt", out_cnt, m_out);
    check("down_time", down_time, m_down);
    check("err_cnt", err_cnt, m_err);
    check("first_err_idx", first_err_idx, m_first);
    check("err_flag", err_flag, m_eflag);
    check("underrun", underrun, m_under);
    check("timeout", timeout, m_tout);
    check("done", done, m_st == 2);
  end

  // ---------------- loopback device model ----------------
  bit lb_on = 1, corrupt = 0, man_chk = 0, last_ce = 0;
  bit pe[3], lb_en_r;
  logic [DW-1:0] pd[3], lb_data_r;
  int lb_cnt;
  int drain_cycles;

  always @(posedge clk) last_ce = clk_en;

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin pe[i] = 0; pd[i] = '0; end
      lb_en_r = 0; lb_data_r = '0; lb_cnt = 0; drain_cycles = 0;
    end else begin
      if (dut_stream_end && !done) drain_cycles++;
      if (last_ce) begin
        lb_en_r = pe[2]; lb_data_r = pd[2];
        pe[2] = pe[1]; pd[2] = pd[1];
        pe[1] = pe[0]; pd[1] = pd[0];
        pe[0] = dut_en && lb_on; pd[0] = dut_data;
        if (lb_en_r) begin
          if (corrupt && lb_cnt == 17) lb_data_r = lb_data_r ^ 8'h01;
          lb_cnt++;
        end
      end
    end
    chk_en = lb_en_r | man_chk;
    chk_data = lb_data_r;
  end

  // ---------------- stimulus ----------------
  task automatic zero_outputs(input string tag);
    check({tag, ".src_ready"}, src_ready, 0);
    check({tag, ".dut_en"}, dut_en, 0);
    check({tag, ".dut_data"}, dut_data, 0);
    check({tag, ".stream_end"}, dut_stream_end, 0);
    check({tag, ".in_cnt"}, in_cnt, 0);
    check({tag, ".out_cnt"}, out_cnt, 0);
    check({tag, ".err_cnt"}, err_cnt, 0);
    check({tag, ".done"}, done, 0);
  endtask

  task automatic restart(input bit lb, input bit corr);
    @(posedge clk); #2;
    rst_n = 0; src_valid = 0; src_last = 0; man_chk = 0; dut_prog_full = 0; clk_en = 1;
    lb_on = lb; corrupt = corr;
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
  endtask

  task automatic run(input int n, input int pf_s, input int pf_l, input int ce_s, input int ce_l,
                     input int rst_at, input int max_c, input int wait_c, input bit exp_done);
    int idx = 0, c = 0;
    bit fire;
    while (idx < n && c < max_c) begin
      dut_prog_full = (c >= pf_s) && (c < pf_s + pf_l);
      clk_en = !((c >= ce_s) && (c < ce_s + ce_l));
      src_valid = 1; src_data = idx[DW-1:0]; src_last = (idx == n - 1);
      if (c == rst_at) begin
        check("pre_reset.in_cnt", in_cnt, 100);
        rst_n = 0;
        #1 zero_outputs("async_reset");
        src_valid = 0; src_last = 0;
        return;
      end
      @(negedge clk);
      fire = src_valid && src_ready;
      @(posedge clk); #2;
      if (fire) idx++;
      c++;
    end
    src_valid = 0; src_last = 0; dut_prog_full = 0; clk_en = 1;
    for (int k = 0; k < wait_c && !done; k++) begin
      @(posedge clk); #2;
    end
    if (exp_done) check("done_within_bound", done, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    #1 zero_outputs("reset");
    repeat (2) @(posedge clk);
    #2 rst_n = 1; clk_en = 1;

    // loopback, 1000 incrementing bytes
    run(1000, -1, 0, -1, 0, -1, 5000, 100, 1);
    check("t1.in_cnt", in_cnt, 1000); check("t1.out_cnt", out_cnt, 1000);
    check("t1.err_cnt", err_cnt, 0); check("t1.done", done, 1);
    check("t1.stream_end", dut_stream_end, 1); check("t1.timeout", timeout, 0);

    // word 17 corrupted
    restart(1, 1);
    run(1000, -1, 0, -1, 0, -1, 5000, 100, 1);
    check("t2.err_cnt", err_cnt, 1); check("t2.first_err_idx", first_err_idx, 17);
    check("t2.err_flag", err_flag, 1); check("t2.out_cnt", out_cnt, 1000); check("t2.done", done, 1);
    check("t2h.out_cnt", h_out_cnt, 18); check("t2h.err_cnt", h_err_cnt, 1);
    check("t2h.first_err_idx", h_first_err_idx, 17); check("t2h.done", h_done, 0);
    check("t2h.src_ready", h_src_ready, 0); check("t2h.dut_en", h_dut_en, 0);

    // prog_full stall of 50 feed cycles
    restart(1, 0);
    run(200, 60, 50, -1, 0, -1, 2000, 100, 1);
    check("t3.down_time", down_time, 50); check("t3.err_cnt", err_cnt, 0);
    check("t3.in_cnt", in_cnt, 200); check("t3.out_cnt", out_cnt, 200);

    // device never returns, 100-byte source fills the FIFO
    restart(0, 0);
    run(100, -1, 0, -1, 0, -1, 200, 0, 0);
    check("t4.in_cnt", in_cnt, 64); check("t4.src_ready", src_ready, 0);
    check("t4.stream_end", dut_stream_end, 0); check("t4.done", done, 0);

    // device never returns, 10-byte source drains into timeout
    restart(0, 0);
    run(10, -1, 0, -1, 0, -1, 100, 1100, 1);
    check("t5.timeout", timeout, 1); check("t5.done", done, 1);
    check("t5.in_cnt", in_cnt, 10); check("t5.out_cnt", out_cnt, 0);
    check("t5.drain_cycles", drain_cycles, 1024);

    // chk_en with empty FIFO
    restart(0, 0);
    @(posedge clk); #2 man_chk = 1;
    @(posedge clk); #2 man_chk = 0;
    @(posedge clk); #2;
    check("t6.underrun", underrun, 1); check("t6.err_cnt", err_cnt, 1);
    check("t6.first_err_idx", first_err_idx, 0); check("t6.out_cnt", out_cnt, 0);

    // clk_en held low for 20 cycles mid-stream
    restart(1, 0);
    run(1000, -1, 0, 300, 20, -1, 5000, 100, 1);
    check("t7.in_cnt", in_cnt, 1000); check("t7.out_cnt", out_cnt, 1000);
    check("t7.err_cnt", err_cnt, 0); check("t7.down_time", down_time, 0);

    // reset mid-feed, then a fresh run
    restart(1, 0);
    run(1000, -1, 0, -1, 0, 100, 5000, 0, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    run(50, -1, 0, -1, 0, -1, 500, 100, 1);
    check("t8.in_cnt", in_cnt, 50); check("t8.out_cnt", out_cnt, 50);
    check("t8.err_cnt", err_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end
endmodule
